// File: rtl/clint_mmio_responder_if.sv
// MMIO request/valid bundle between the core-side bridge and the CLINT responder.
// The master drives the request and holds it until valid_mem.
interface clint_mmio_responder_if;
    logic [63:0] address_mem;
    logic        ren_mem;
    logic        wen_mem;
    logic [7:0]  wmask_mem;
    logic [63:0] wdata_mem;
    logic [63:0] rdata_mem;
    logic        valid_mem;

    modport master (
        output address_mem, ren_mem, wen_mem, wmask_mem, wdata_mem,
        input  rdata_mem, valid_mem
    );

    modport slave (
        input  address_mem, ren_mem, wen_mem, wmask_mem, wdata_mem,
        output rdata_mem, valid_mem
    );
endinterface

// File: rtl/clint_mmio_responder.sv
// CLINT register block (msip, mtimecmp, mtime) behind a fixed-latency
// MMIO responder; drives software and timer interrupt lines.
module clint_mmio_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    clint_mmio_responder_if.slave  bus,
    output logic                   soft_irq,
    output logic                   timer_irq
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [3:0] CNT_INIT =
        (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic        wen_q;
    logic        valid_q;
    logic [63:0] rdata_q;
    logic        msip_q;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtime_q;
    logic        tirq_q;

    logic        req;
    logic        commit;
    logic        c_wen;
    logic [63:0] c_addr;
    logic [63:0] c_wdata;
    logic [7:0]  c_wmask;
    logic [63:0] c_off;
    logic        hit_msip;
    logic        hit_cmp;
    logic        hit_time;
    logic [63:0] rd_val;
    logic [63:0] wr_val;

    function automatic logic [63:0] merge(
        input logic [63:0] old,
        input logic [63:0] data,
        input logic [7:0]  mask
    );
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = mask[i] ? data[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    assign req = bus.ren_mem | bus.wen_mem;

    // With zero latency the access commits straight from the live bus.
    always_comb begin
        commit  = 1'b0;
        c_wen   = wen_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_wmask = wmask_q;
        unique case (state_q)
            IDLE: begin
                commit  = req && (LATENCY == 0);
                c_wen   = bus.wen_mem;
                c_addr  = bus.address_mem;
                c_wdata = bus.wdata_mem;
                c_wmask = bus.wmask_mem;
            end
            BUSY:    commit = (cnt_q == 4'd0);
            default: ;
        endcase
    end

    assign c_off    = c_addr - BASE_ADDR;
    assign hit_msip = (c_off & ~64'h7) == 64'h0000;
    assign hit_cmp  = (c_off & ~64'h7) == 64'h4000;
    assign hit_time = (c_off & ~64'h7) == 64'hBFF8;

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            hit_msip: rd_val = {63'b0, msip_q};
            hit_cmp:  rd_val = mtimecmp_q;
            hit_time: rd_val = mtime_q;
            default:  ;
        endcase
    end

    assign wr_val = merge(rd_val, c_wdata, c_wmask);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            wen_q      <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
            mtime_q    <= '0;
            tirq_q     <= 1'b0;
        end else begin
            tirq_q  <= (mtime_q >= mtimecmp_q);
            mtime_q <= mtime_q + 64'd1;
            valid_q <= commit;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= bus.address_mem;
                        wdata_q <= bus.wdata_mem;
                        wmask_q <= bus.wmask_mem;
                        wen_q   <= bus.wen_mem;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A write (including read+write) returns zero data.
            if (commit) begin
                if (c_wen) begin
                    rdata_q <= '0;
                    if (hit_msip) msip_q     <= wr_val[0];
                    if (hit_cmp)  mtimecmp_q <= wr_val;
                    if (hit_time) mtime_q    <= wr_val;
                end else begin
                    rdata_q <= rd_val;
                end
            end
        end
    end

    assign bus.rdata_mem = rdata_q;
    assign bus.valid_mem = valid_q;
    assign soft_irq      = msip_q;
    assign timer_irq     = tirq_q;

endmodule

// File: tb/tb_clint_mmio_responder.sv
// Directed + randomized bench for clint_mmio_responder against a
// time-based reference model of the CLINT registers.
module tb_clint_mmio_responder;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic soft2, tirq2, soft0, tirq0;

    clint_mmio_responder_if if2();
    clint_mmio_responder_if if0();

    clint_mmio_responder #(.BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
        .clk(clk), .rstn(rstn), .bus(if2),
        .soft_irq(soft2), .timer_irq(tirq2)
    );

    clint_mmio_responder #(.BASE_ADDR(BASE), .LATENCY(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .bus(if0),
        .soft_irq(soft0), .timer_irq(tirq0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    longint cyc = 0;

    // mtime is modelled as a base value plus elapsed cycles.
    logic        m_msip;
    logic [63:0] m_cmp;
    logic [63:0] m_base;
    longint      m_cyc;
    longint      m0_cyc;

    function automatic logic [63:0] mt_at(input longint c);
        return m_base + 64'(c - m_cyc);
    endfunction

    function automatic logic [63:0] mt0_at(input longint c);
        return 64'(c - m0_cyc);
    endfunction

    function automatic logic [63:0] model_reg(input logic [63:0] off, input longint c);
        case (off)
            64'h0000: return {63'b0, m_msip};
            64'h4000: return m_cmp;
            64'hBFF8: return mt_at(c);
            default:  return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] d,
                                           input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_tirq(input string tag);
        chk(tag, 64'(tirq2), 64'(mt_at(cyc - 1) >= m_cmp));
    endtask

    task automatic model_reset();
        m_msip = 1'b0;
        m_cmp  = '1;
        m_base = '0;
        m_cyc  = cyc;
        m0_cyc = cyc;
    endtask

    task automatic acc(input string tag, input logic [63:0] off, input bit rd,
                       input bit wr, input logic [7:0] m, input logic [63:0] d,
                       input bit drop);
        longint c0, cc;
        logic [63:0] old, mrg;
        bit seen;
        c0 = cyc;
        if2.address_mem = BASE + off + 64'($urandom_range(0, 7));
        if2.ren_mem = rd;
        if2.wen_mem = wr;
        if2.wmask_mem = m;
        if2.wdata_mem = d;
        seen = 1'b0;
        for (int k = 0; k < LAT + 4 && !seen; k++) begin
            tick();
            if (drop && k == 0) begin
                if2.ren_mem = 1'b0;
                if2.wen_mem = 1'b0;
                if2.address_mem = 64'($urandom);
                if2.wdata_mem = 64'($urandom);
            end
            seen = if2.valid_mem;
        end
        chk({tag, "_lat"}, 64'(cyc - c0), 64'(LAT + 1));
        cc = c0 + LAT;
        old = model_reg(off, cc);
        if (wr) begin
            mrg = bmerge(old, d, m);
            case (off)
                64'h0000: m_msip = mrg[0];
                64'h4000: m_cmp = mrg;
                64'hBFF8: begin m_base = mrg; m_cyc = cc + 1; end
                default: ;
            endcase
            if (rd) chk({tag, "_rdwr0"}, if2.rdata_mem, 64'h0);
        end else begin
            chk({tag, "_rdata"}, if2.rdata_mem, old);
        end
        chk({tag, "_soft"}, 64'(soft2), 64'(m_msip));
        if2.ren_mem = 1'b0;
        if2.wen_mem = 1'b0;
        tick();
        chk({tag, "_pulse"}, 64'(if2.valid_mem), 64'h0);
        chk_tirq({tag, "_tirq"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] off, d;
        logic [7:0]  m;
        int sel, op, gap;
        longint c0;

        if2.address_mem = '0; if2.ren_mem = 0; if2.wen_mem = 0;
        if2.wmask_mem = '0; if2.wdata_mem = '0;
        if0.address_mem = '0; if0.ren_mem = 0; if0.wen_mem = 0;
        if0.wmask_mem = '0; if0.wdata_mem = '0;

        repeat (3) tick();
        chk("rst_valid", 64'(if2.valid_mem), 64'h0);
        chk("rst_rdata", if2.rdata_mem, 64'h0);
        chk("rst_soft", 64'(soft2), 64'h0);
        chk("rst_tirq", 64'(tirq2), 64'h0);
        chk("rst_valid0", 64'(if0.valid_mem), 64'h0);
        rstn = 1'b1;
        model_reset();

        acc("rd_mtime", 64'hBFF8, 1, 0, 8'h00, 64'h0, 0);

        acc("wr_cmp20", 64'h4000, 0, 1, 8'hFF, 64'h20, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk_tirq("tirq_watch");
        end
        chk("tirq_hi", 64'(tirq2), 64'h1);
        acc("wr_cmp1s", 64'h4000, 0, 1, 8'hFF, '1, 0);
        chk("tirq_clr", 64'(tirq2), 64'h0);

        acc("wr_msip", 64'h0, 0, 1, 8'h01, 64'hFFFF_FFFF, 0);
        chk("soft_set", 64'(soft2), 64'h1);
        acc("rd_msip", 64'h0, 1, 0, 8'h00, 64'h0, 0);
        chk("msip_rb", if2.rdata_mem, 64'h1);
        acc("clr_msip", 64'h0, 0, 1, 8'hFF, 64'h0, 0);
        chk("soft_clr", 64'(soft2), 64'h0);

        acc("wr_mt_hi", 64'hBFF8, 0, 1, 8'hF0, 64'h1234_5678_0000_0000, 0);
        repeat (3) tick();
        acc("rd_mt_hi", 64'hBFF8, 1, 0, 8'h00, 64'h0, 0);
        chk("mt_upper", 64'(if2.rdata_mem[63:32]), 64'h1234_5678);

        acc("rdwr_msip", 64'h0, 1, 1, 8'h01, 64'h1, 0);
        acc("drop_rd", 64'h4000, 1, 0, 8'h00, 64'h0, 1);
        acc("drop_wr", 64'h0, 0, 1, 8'h01, 64'h0, 1);

        acc("wr_wrap", 64'hBFF8, 0, 1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        repeat (2) tick();
        acc("rd_wrap", 64'hBFF8, 1, 0, 8'h00, 64'h0, 0);
        acc("rd_unmap", 64'h8000, 1, 0, 8'h00, 64'h0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: off = 64'h0000;
                1: off = 64'h4000;
                2: off = 64'hBFF8;
                3: off = 64'h8000;
                default: off = 64'($urandom_range(1, 511)) << 3;
            endcase
            op = $urandom_range(0, 2);
            m = 8'($urandom);
            d = {$urandom, $urandom};
            if (sel == 2 && $urandom_range(0, 3) == 0) d = 64'hFFFF_FFFF_FFFF_FFF8;
            acc("rand", off, op != 1, op != 0, m, d, $urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk_tirq("rand_gap_tirq");
            end
        end

        if0.address_mem = BASE + 64'hBFF8;
        if0.ren_mem = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("b2b_valid", 64'(if0.valid_mem), 64'((cyc - c0) % 2 == 1));
            if (if0.valid_mem) chk("b2b_rdata", if0.rdata_mem, mt0_at(cyc - 1));
        end
        if0.ren_mem = 1'b0;
        tick();
        chk("b2b_stop", 64'(if0.valid_mem), 64'h0);
        if0.address_mem = BASE + 64'h8000;
        if0.ren_mem = 1'b1;
        tick();
        chk("l0_unmap_v", 64'(if0.valid_mem), 64'h1);
        chk("l0_unmap_d", if0.rdata_mem, 64'h0);
        if0.ren_mem = 1'b0;
        tick();
        chk("l0_unmap_p", 64'(if0.valid_mem), 64'h0);

        if2.address_mem = BASE + 64'h4000;
        if2.wen_mem = 1'b1;
        if2.wmask_mem = 8'hFF;
        if2.wdata_mem = 64'h55;
        tick();
        if2.wen_mem = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_v", 64'(if2.valid_mem), 64'h0);
        tick();
        tick();
        chk("mid_rst_v2", 64'(if2.valid_mem), 64'h0);
        chk("mid_rst_tirq", 64'(tirq2), 64'h0);
        rstn = 1'b1;
        model_reset();
        acc("post_rst_cmp", 64'h4000, 1, 0, 8'h00, 64'h0, 0);
        chk("cmp_ones", if2.rdata_mem, '1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
